// File: rtl/serial_receiver.sv
// serial_receiver: asynchronous serial line receiver with a byte FIFO.
// RX is synchronized, framed by a one-hot FSM (start/data/stop plus break
// recovery) and each good byte is pushed into a DEPTH-entry FIFO that the
// host drains with rd_en. Default frame is 8N1.
// Optional feature: define SERIAL_RX_PARITY_EN for 8E1 frames with an even
// parity check (parity_error pulses and the byte is discarded on mismatch).
module serial_receiver #(
    parameter int CLK_IN = 0,
    parameter int BAUD   = 0,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     RX,
    input  logic                     rd_en,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic                     overrun,
    output logic                     framing_error,
    output logic                     parity_error
);

    // Guard against the zero defaults so elaboration never divides by zero.
    localparam int          CNT_RAW   = (BAUD > 0) ? (CLK_IN / BAUD) : 4;
    localparam logic [15:0] COUNT     = 16'(CNT_RAW);
    localparam logic [15:0] BIT_LAST  = COUNT - 16'd1;
    localparam logic [15:0] HALF_LAST = (COUNT >> 1) - 16'd1;
    localparam int          AW        = $clog2(DEPTH);

    // One-hot state encoding.
    localparam logic [5:0] S_IDLE   = 6'b000001;
    localparam logic [5:0] S_START  = 6'b000010;
    localparam logic [5:0] S_DATA   = 6'b000100;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [5:0] S_PARITY = 6'b001000;
`endif
    localparam logic [5:0] S_STOP   = 6'b010000;
    localparam logic [5:0] S_BREAK  = 6'b100000;

    // Synchronizer and edge-detect history.
    logic rx_meta_q, rx_s_q, rx_prev_q;

    // Frame FSM state.
    logic [5:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_pos_q, bit_pos_d;
    logic [7:0]  shift_q, shift_d;
    logic        fe_q, fe_d;
    logic        push;
`ifdef SERIAL_RX_PARITY_EN
    logic        pe_q, pe_d;
    logic        par_bad_q, par_bad_d;
`endif

    // FIFO state.
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]  dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        full, do_pop, do_push;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (srst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Frame FSM: bit timing, sampling, and push/error decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_pos_d = bit_pos_q;
        shift_d   = shift_q;
        fe_d      = 1'b0;
        push      = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        pe_d      = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = S_START;
                    cnt_d     = 16'd0;
                    bit_pos_d = 3'd0;
`ifdef SERIAL_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_START: begin
                // Mid-start-bit check rejects short glitches on the line.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d            = 16'd0;
                    shift_d[bit_pos_q] = rx_s_q;
                    if (bit_pos_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_pos_d = bit_pos_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: parity bit equals XOR of the data bits.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_STOP;
                    if (rx_s_q != (^shift_q)) begin
                        pe_d      = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        push    = !par_bad_q;
`else
                        push    = 1'b1;
`endif
                    end else begin
                        state_d = S_BREAK;
                        fe_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_BREAK: begin
                // Wait out a held-low line before looking for a new start bit.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_pos_q <= 3'd0;
            shift_q   <= 8'd0;
            fe_q      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_pos_q <= bit_pos_d;
            shift_q   <= shift_d;
            fe_q      <= fe_d;
`ifdef SERIAL_RX_PARITY_EN
            pe_q      <= pe_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    // FIFO pointer, count, read-port and overrun next-state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        valid_d   = do_pop;
        overrun_d = overrun_q | (push && !do_push);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control and read-port registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dout_q    <= 8'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign dout          = dout_q;
    assign valid         = valid_q;
    assign data_count    = count_q;
    assign overrun       = overrun_q;
    assign framing_error = fe_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_error  = pe_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Testbench for serial_receiver: directed frames with a scoreboard queue of
// expected bytes, drained by a monitor whenever valid is presented.
module tb_serial_receiver;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       srst;
    logic       RX;
    logic       rd_en;
    logic [7:0] dout;
    logic       valid;
    logic       empty;
    logic [$clog2(DEPTH):0] data_count;
    logic       overrun;
    logic       framing_error;
    logic       parity_error;

    int checks = 0;
    int fails  = 0;
    int vld_cnt = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    logic [7:0] exp_q [$];

    serial_receiver #(.CLK_IN(1000000), .BAUD(100000), .DEPTH(DEPTH)) dut (
        .clk(clk), .srst(srst), .RX(RX), .rd_en(rd_en), .dout(dout),
        .valid(valid), .empty(empty), .data_count(data_count),
        .overrun(overrun), .framing_error(framing_error),
        .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compare every presented byte against the scoreboard.
    always @(negedge clk) begin
        if (!srst) begin
            if (valid) begin
                vld_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: dout=%02h with nothing expected", dout);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        fails++;
                        $display("FAIL dout: got %02h expected %02h", dout, e);
                    end
                end
            end
            if (framing_error) fe_cnt++;
            if (parity_error)  pe_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame, 10 clocks per bit; stop_low>0 holds the stop bit low that long.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input int stop_low);
        RX = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(10);
        end
`ifdef SERIAL_RX_PARITY_EN
        RX = pbit;
        tick(10);
`endif
        if (stop_low > 0) begin
            RX = 1'b0;
            tick(stop_low);
        end
        RX = 1'b1;
        tick(10);
        tick(4);
    endtask

    task automatic pop_one(input string name);
        int v0;
        v0 = vld_cnt;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
        chk(name, vld_cnt, v0 + 1);
    endtask

    initial begin
        int fe0, pe0, v0;
        logic [7:0] b;
        RX = 1'b1;
        rd_en = 1'b0;
        srst = 1'b1;
        tick(3);
        srst = 1'b0;
        tick(1);
        chk("reset_empty", int'(empty), 1);
        chk("reset_count", int'(data_count), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_dout", int'(dout), 0);
        chk("reset_overrun", int'(overrun), 0);

        // Pop while empty is ignored.
        v0 = vld_cnt;
        rd_en = 1'b1;
        tick(3);
        rd_en = 1'b0;
        tick(2);
        chk("pop_empty_no_valid", vld_cnt, v0);

        // Single byte 0xA5.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 0);
        chk("a5_count", int'(data_count), 1);
        chk("a5_empty", int'(empty), 0);
        pop_one("a5_pop");
        chk("a5_count_after", int'(data_count), 0);
        chk("a5_empty_after", int'(empty), 1);

        // Short glitch on RX.
        fe0 = fe_cnt;
        RX = 1'b0;
        tick(3);
        RX = 1'b1;
        tick(30);
        chk("glitch_count", int'(data_count), 0);
        chk("glitch_no_fe", fe_cnt, fe0);

        // Framing error then recovery.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 30);
        chk("fe_pulse", fe_cnt, fe0 + 1);
        chk("fe_count", int'(data_count), 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 0);
        chk("after_fe_count", int'(data_count), 1);
        pop_one("after_fe_pop");

        // Fill, then push into full FIFO with a simultaneous pop.
        for (int i = 0; i < 5; i++) begin
            b = 8'h11 + 8'(i);
            exp_q.push_back(b);
        end
        send_frame(8'h11, 1'b0, 0);
        send_frame(8'h12, 1'b0, 0);
        send_frame(8'h13, 1'b1, 0);
        send_frame(8'h14, 1'b0, 0);
        chk("full_count", int'(data_count), 4);
        v0 = vld_cnt;
        fork
            send_frame(8'h15, 1'b1, 0);
            begin
`ifdef SERIAL_RX_PARITY_EN
                tick(107);
`else
                tick(97);
`endif
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        join
        chk("simul_valid", vld_cnt, v0 + 1);
        chk("simul_count", int'(data_count), 4);
        chk("simul_no_overrun", int'(overrun), 0);
        for (int i = 0; i < 4; i++) pop_one("simul_drain");
        chk("simul_drained", int'(data_count), 0);

        // Overrun: five bytes, no pops.
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h02, 1'b1, 0);
        send_frame(8'h03, 1'b0, 0);
        send_frame(8'h04, 1'b1, 0);
        send_frame(8'h05, 1'b0, 0);
        chk("ovr_count", int'(data_count), 4);
        chk("ovr_flag", int'(overrun), 1);
        for (int i = 0; i < 4; i++) pop_one("ovr_pop");
        chk("ovr_drained", int'(data_count), 0);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset during bit 4 of 0xFF.
        RX = 1'b0;
        tick(10);
        RX = 1'b1;
        tick(45);
        srst = 1'b1;
        tick(2);
        srst = 1'b0;
        tick(1);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_count", int'(data_count), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_overrun", int'(overrun), 0);
        tick(100);
        chk("midrst_no_push", int'(data_count), 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 0);
        chk("after_rst_count", int'(data_count), 1);
        pop_one("after_rst_pop");

`ifdef SERIAL_RX_PARITY_EN
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b0, 0);
        chk("par_bad_pulse", pe_cnt, pe0 + 1);
        chk("par_bad_count", int'(data_count), 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 0);
        chk("par_good_count", int'(data_count), 1);
        chk("par_good_no_pulse", pe_cnt, pe0 + 1);
        pop_one("par_good_pop");
`else
        pe0 = pe_cnt;
`endif
        chk("no_stray_parity", pe_cnt, pe0);

        tick(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
